// File: rtl/axi_mem_pkg.sv
// Shared AXI constants, engine state types and address stepping for the
// on-chip memory responder.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int ADDR_MAX_WIDTH = 64;

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // WRAP and reserved bursts step like INCR; only their response differs.
  function automatic logic [ADDR_MAX_WIDTH-1:0] next_addr(
    input logic [ADDR_MAX_WIDTH-1:0] addr,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    logic [ADDR_MAX_WIDTH-1:0] result;
    case (burst)
      BURST_FIXED:           result = addr;
      BURST_INCR, BURST_WRAP: result = addr + (ADDR_MAX_WIDTH'(1) << size);
      default:               result = addr + (ADDR_MAX_WIDTH'(1) << size);
    endcase
    return result;
  endfunction

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Byte-enabled word memory with one synchronous write port and one
// registered read port; contents are not reset.
module axi_mem_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [DEPTH_LOG2-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Sampling the array here returns pre-write data on a same-word collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory slave: independent read and write burst engines, one
// outstanding burst each, one beat per cycle, backed by axi_mem_ram.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready
);

  localparam int LSB = $clog2(DATA_WIDTH/8);

  rd_state_t                 r_state;
  logic [ADDR_WIDTH-1:0]     r_addr, r_addr_next;
  logic [7:0]                r_len, r_beat;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic                      r_start, r_advance;
  logic [MEM_ADDR_WIDTH-1:0] rd_idx;

  wr_state_t                 w_state;
  logic [ADDR_WIDTH-1:0]     w_addr, w_addr_next;
  logic [7:0]                w_len, w_beat;
  logic [2:0]                w_size;
  logic [1:0]                w_burst;
  logic                      w_ok, w_err, w_accept;

  assign r_addr_next = ADDR_WIDTH'(next_addr(ADDR_MAX_WIDTH'(r_addr), r_size, r_burst));
  assign w_addr_next = ADDR_WIDTH'(next_addr(ADDR_MAX_WIDTH'(w_addr), w_size, w_burst));

  assign r_start   = (r_state == R_IDLE) && s_axi_arvalid && s_axi_arready;
  assign r_advance = (r_state == R_DATA) && s_axi_rvalid && s_axi_rready && !s_axi_rlast;
  // The read port is addressed one beat ahead so rdata lands with rvalid.
  assign rd_idx    = r_start ? s_axi_araddr[MEM_ADDR_WIDTH+LSB-1:LSB]
                             : r_addr_next[MEM_ADDR_WIDTH+LSB-1:LSB];
  assign w_accept  = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;

  axi_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (MEM_ADDR_WIDTH)
  ) u_ram (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .wr_en   (w_accept && w_ok),
    .wr_idx  (w_addr[MEM_ADDR_WIDTH+LSB-1:LSB]),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .rd_en   (r_start || r_advance),
    .rd_idx  (rd_idx),
    .rd_data (s_axi_rdata)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (r_start) begin
            s_axi_arready <= 1'b0;
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_beat        <= '0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= burst_supported(s_axi_arburst) ? RESP_OKAY : RESP_SLVERR;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_addr_next;
              r_beat      <= r_beat + 8'd1;
              s_axi_rlast <= (r_beat + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Burst length and wlast disagreeing only poisons the response; the
  // burst always terminates on the master's wlast.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      w_addr        <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_ok          <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b0;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_beat        <= '0;
            w_ok          <= burst_supported(s_axi_awburst);
            w_err         <= !burst_supported(s_axi_awburst);
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_accept) begin
            w_addr <= w_addr_next;
            w_beat <= w_beat + 8'd1;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || (w_beat != w_len)) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else if (w_beat == w_len) begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
